uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- 8N1 UART receiver: the receive side matching the core's uart_txd output.
- Samples the asynchronous rxd pin and reassembles bytes.
- Buffers received bytes in a small first-word-fall-through FIFO.
- Exposes a pop/valid interface and sticky error flags; the memory block maps these as a read-only data/status register pair.

Parameters:
CLKS_PER_BIT, 16, clk cycles per bit period (>=4); fixes baud rate.
FIFO_DEPTH, 4, receive FIFO entries; power of 2, >=2.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
rxd  in  1  serial input, idle high, asynchronous to clk
rx_data  out  8  FIFO head byte; valid only when rx_valid=1
rx_valid  out  1  FIFO not empty
rx_pop  in  1  consume head byte this cycle
rx_level  out  $clog2(FIFO_DEPTH+1)  number of bytes held
frame_err  out  1  sticky: a stop bit was sampled low
overrun  out  1  sticky: a byte arrived while the FIFO was full
err_clr  in  1  clears frame_err and overrun

Behaviour:
- Reset (async assert, sync release):
  - FSM=IDLE; FIFO empty.
  - rx_valid=0, rx_level=0, rx_data=0, frame_err=0, overrun=0.
  - Both synchroniser flops =1.
- Input path: 2-flop synchroniser rxd->rxd_s; all decisions use rxd_s only.
- Bit counter counts 0..CLKS_PER_BIT-1; bit index counts 0..7.
- FSM:
  - IDLE: rxd_s==0 -> START; clear counter.
  - START: at count CLKS_PER_BIT/2-1, sample rxd_s. If 1 (glitch) -> IDLE, nothing recorded. If 0 -> DATA; clear counter and index.
  - DATA: at count CLKS_PER_BIT-1, shift rxd_s in LSB-first. After bit index 7 -> STOP.
  - STOP: at count CLKS_PER_BIT-1, sample rxd_s. If 1, push byte -> IDLE. If 0, set frame_err, discard byte -> BREAK.
  - BREAK: wait for rxd_s==1 -> IDLE. A held-low line yields exactly one frame_err and no bytes.
- Latency: rx_valid rises the cycle after the stop-bit sample, about 2+(9.5*CLKS_PER_BIT) cycles after the rxd falling edge.
- Back-to-back frames: IDLE is re-entered mid stop-bit, so a start bit immediately after the stop bit is caught.
- FIFO (first-word-fall-through):
  - Push when STOP succeeds. Pop when rx_pop && rx_valid.
  - rx_pop while empty is ignored.
  - Push and pop in the same cycle: both occur, level unchanged. When full, this push is accepted and overrun is not set.
  - Push while full without pop: byte dropped, overrun set, contents unchanged.
  - Pointers wrap modulo FIFO_DEPTH. rx_level is registered and exact.
- Errors:
  - err_clr clears both flags next cycle.
  - An error event in the same cycle as err_clr wins; the flag stays 1.
- Reset mid-frame aborts reception, empties the FIFO and returns to IDLE; no partial byte is pushed.

Decomposition:
- Shared package/include:
  - FSM state encodings UART_RX_IDLE/START/DATA/STOP/BREAK.
  - UART_DATA_BITS=8.
  - Default CLKS_PER_BIT, so the transmitter and receiver derive the baud rate from one constant.
- One sub-module, uart_rx_fifo (parameter DEPTH):
  - Ports: push, push_data, pop, head, level, full, empty.
  - Same clk/rst_n.
  - Reusable by a future TX buffer.

Test Plan:
- Send 0xA5 (8N1, CLKS_PER_BIT=16) -> rx_valid=1, rx_data=0xA5, rx_level=1. rx_pop one cycle -> rx_valid=0, rx_level=0.
- rxd low pulse of 4 cycles (less than half a bit), then idle -> no push, rx_valid=0, frame_err=0, FSM back in IDLE.
- Send 0x3C with stop bit 0, then line high -> frame_err=1, rx_level=0. Next 0x3C with a good stop bit -> received. err_clr -> frame_err=0.
- FIFO_DEPTH=4, send 0x01..0x05 with no pops -> rx_level=4, overrun=1. Pops return 0x01,0x02,0x03,0x04, then rx_valid=0.
- Two frames 0x55,0xAA with zero idle gap, plus rx_pop asserted on the push cycle of the second -> both bytes delivered in order, no overrun.
- Assert rst_n=0 during DATA bit 4 of a frame, release, send 0x7E -> only 0x7E received, flags 0.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: constants and state encodings shared by the UART receive path.
// The default bit period lives here so the transmitter and receiver derive
// the baud rate from the same constant.
package uart_rx_pkg;

  localparam int UART_DATA_BITS            = 8;
  localparam int UART_CLKS_PER_BIT_DEFAULT = 16;

  typedef enum logic [2:0] {
    UART_RX_IDLE  = 3'd0,
    UART_RX_START = 3'd1,
    UART_RX_DATA  = 3'd2,
    UART_RX_STOP  = 3'd3,
    UART_RX_BREAK = 3'd4
  } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through byte FIFO with a registered, exact
// fill level. A push into a full FIFO is accepted only when a pop happens in
// the same cycle; otherwise it is dropped and the caller decides what to flag.
//
// Ports:
//   clk, rst_n   clock, async active-low reset
//   push         write push_data (ignored when full unless popping)
//   push_data    byte to write
//   pop          consume head (ignored when empty)
//   head         current head byte (0 after reset)
//   level        number of bytes held, 0..DEPTH
//   full, empty  level == DEPTH / level == 0
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic [UART_DATA_BITS-1:0]      push_data,
  input  logic                           pop,
  output logic [UART_DATA_BITS-1:0]      head,
  output logic [$clog2(DEPTH+1)-1:0]     level,
  output logic                           full,
  output logic                           empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  logic [UART_DATA_BITS-1:0] mem_q [DEPTH];
  logic [AW-1:0]             wr_ptr_q;
  logic [AW-1:0]             rd_ptr_q;
  logic [LW-1:0]             level_q;
  logic                      do_push;
  logic                      do_pop;

  assign full    = (level_q == LVL_FULL);
  assign empty   = (level_q == '0);
  assign do_pop  = pop && !empty;
  // a simultaneous pop frees the slot this push needs
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_ptr_q];
  assign level   = level_q;

  // DEPTH is a power of two, so pointers wrap by natural overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver. Synchronises rxd, recovers bytes by mid-bit
// sampling, buffers them in a FWFT FIFO and keeps sticky error flags.
//
// Ports:
//   clk, rst_n   clock, async active-low reset
//   rxd          serial input, idle high, asynchronous
//   rx_data      FIFO head byte (valid when rx_valid)
//   rx_valid     FIFO not empty
//   rx_pop       consume head byte
//   rx_level     bytes held in the FIFO
//   frame_err    sticky: stop bit sampled low
//   overrun      sticky: byte dropped because FIFO was full
//   err_clr      clear both sticky flags
//
// state  | meaning
// IDLE   | line idle, waiting for rxd_s low
// START  | confirm start bit at half-bit point
// DATA   | sample 8 data bits at mid-bit, LSB first
// STOP   | sample stop bit at mid-bit; push or flag framing error
// BREAK  | line held low after framing error, wait for high
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              rxd,
  output logic [7:0]                        rx_data,
  output logic                              rx_valid,
  input  logic                              rx_pop,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   rx_level,
  output logic                              frame_err,
  output logic                              overrun,
  input  logic                              err_clr
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(UART_DATA_BITS - 1);

  logic rxd_meta;
  logic rxd_s;

  uart_rx_state_e            state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      push;
  logic                      frame_set;

  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      pop_eff;
  logic                      overrun_set;
  logic                      frame_err_q;
  logic                      overrun_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= UART_RX_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frame_set = 1'b0;
    case (state_q)
      UART_RX_IDLE: begin
        cnt_d = '0;
        if (!rxd_s) state_d = UART_RX_START;
      end
      UART_RX_START: begin
        if (cnt_q == CNT_MID) begin
          cnt_d = '0;
          idx_d = '0;
          state_d = rxd_s ? UART_RX_IDLE : UART_RX_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      UART_RX_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rxd_s, shift_q[UART_DATA_BITS-1:1]};
          if (idx_q == IDX_LAST) state_d = UART_RX_STOP;
          else                   idx_d   = idx_q + IW'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      UART_RX_STOP: begin
        // leaving mid stop-bit lets an immediately following start bit be seen
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rxd_s) begin
            push    = 1'b1;
            state_d = UART_RX_IDLE;
          end else begin
            frame_set = 1'b1;
            state_d   = UART_RX_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      UART_RX_BREAK: begin
        cnt_d = '0;
        if (rxd_s) state_d = UART_RX_IDLE;
      end
      default: state_d = UART_RX_IDLE;
    endcase
  end

  assign pop_eff = rx_pop && !fifo_empty;

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (shift_q),
    .pop       (pop_eff),
    .head      (rx_data),
    .level     (rx_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign overrun_set = push && fifo_full && !pop_eff;

  // a set event in the same cycle as err_clr keeps the flag high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (frame_set)    frame_err_q <= 1'b1;
      else if (err_clr) frame_err_q <= 1'b0;
      if (overrun_set)  overrun_q   <= 1'b1;
      else if (err_clr) overrun_q   <= 1'b0;
    end
  end

  assign rx_valid  = !fifo_empty;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx (CLKS_PER_BIT=16, FIFO_DEPTH=4).
module tb_uart_rx;
  import uart_rx_pkg::*;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_pop;
  logic [2:0] rx_level;
  logic       frame_err;
  logic       overrun;
  logic       err_clr;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_rx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_pop    (rx_pop),
    .rx_level  (rx_level),
    .frame_err (frame_err),
    .overrun   (overrun),
    .err_clr   (err_clr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    rxd = v;
    repeat (CPB) @(negedge clk);
  endtask

  // 160 negedges from call to return; rxd left high
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
    rxd = 1'b1;
  endtask

  task automatic pop_byte();
    rx_pop = 1'b1;
    @(negedge clk);
    rx_pop = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    rxd     = 1'b1;
    rx_pop  = 1'b0;
    err_clr = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_level", 32'(rx_level), 32'd0);
    check("rst_data", 32'(rx_data), 32'h00);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    check("rst_sync", 32'({dut.rxd_meta, dut.rxd_s}), 32'b11);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // single byte 0xA5 then pop
    send_frame(8'hA5, 1'b1);
    check("a5_valid", 32'(rx_valid), 32'd1);
    check("a5_data", 32'(rx_data), 32'hA5);
    check("a5_level", 32'(rx_level), 32'd1);
    pop_byte();
    check("a5_pop_valid", 32'(rx_valid), 32'd0);
    check("a5_pop_level", 32'(rx_level), 32'd0);
    pop_byte();
    check("empty_pop_level", 32'(rx_level), 32'd0);

    // short glitch is rejected
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_valid", 32'(rx_valid), 32'd0);
    check("glitch_ferr", 32'(frame_err), 32'd0);
    check("glitch_state", 32'(dut.state_q), 32'(UART_RX_IDLE));

    // framing error, recovery, clear
    send_frame(8'h3C, 1'b0);
    repeat (20) @(negedge clk);
    check("ferr_set", 32'(frame_err), 32'd1);
    check("ferr_level", 32'(rx_level), 32'd0);
    send_frame(8'h3C, 1'b1);
    check("ferr_good_data", 32'(rx_data), 32'h3C);
    check("ferr_good_level", 32'(rx_level), 32'd1);
    check("ferr_sticky", 32'(frame_err), 32'd1);
    pulse_clr();
    check("ferr_clr", 32'(frame_err), 32'd0);
    pop_byte();
    check("ferr_pop_valid", 32'(rx_valid), 32'd0);

    // overrun: five bytes into a four-deep FIFO
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    check("ovr_level", 32'(rx_level), 32'd4);
    check("ovr_flag", 32'(overrun), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("ovr_data%0d", i), 32'(rx_data), 32'(i));
      pop_byte();
    end
    check("ovr_drain_valid", 32'(rx_valid), 32'd0);
    check("ovr_drain_level", 32'(rx_level), 32'd0);
    pulse_clr();
    check("ovr_clr", 32'(overrun), 32'd0);
    repeat (5) @(negedge clk);

    // back-to-back frames, pop on the second push cycle
    send_frame(8'h55, 1'b1);
    fork
      send_frame(8'hAA, 1'b1);
      begin
        // second push lands on the posedge after negedge 154 of the frame
        repeat (154) @(negedge clk);
        check("b2b_first_data", 32'(rx_data), 32'h55);
        check("b2b_first_level", 32'(rx_level), 32'd1);
        rx_pop = 1'b1;
        @(negedge clk);
        rx_pop = 1'b0;
      end
    join
    check("b2b_second_data", 32'(rx_data), 32'hAA);
    check("b2b_second_level", 32'(rx_level), 32'd1);
    check("b2b_ovr", 32'(overrun), 32'd0);

    // reset during data bit 4
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    rxd = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    rxd   = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst_level", 32'(rx_level), 32'd0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("mid_rst_valid", 32'(rx_valid), 32'd0);
    check("mid_rst_data", 32'(rx_data), 32'h00);
    send_frame(8'h7E, 1'b1);
    check("post_rst_data", 32'(rx_data), 32'h7E);
    check("post_rst_level", 32'(rx_level), 32'd1);
    check("post_rst_ferr", 32'(frame_err), 32'd0);
    check("post_rst_ovr", 32'(overrun), 32'd0);
    pop_byte();
    check("post_rst_empty", 32'(rx_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
